// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared command codes and default debounce length for the stopwatch front end
package stopwatch_pkg;
  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;
endpackage

// File: rtl/cmd_debounce.sv
// cmd_debounce: per-bit synchroniser followed by a whole-vector debouncer
module cmd_debounce
  import stopwatch_pkg::*;
#(
  parameter int W               = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync;
  logic [W-1:0] last;
  logic [CNT_W-1:0] cnt;
  assign sync = sync_q[SYNC_STAGES-1];
  // shift each raw bit through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  // a new code must hold unchanged for DEBOUNCE_CYCLES cycles; any change restarts the count at 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stable <= '0;
      last   <= '0;
      cnt    <= '0;
    end else begin
      last <= sync;
      if (sync == stable) cnt <= '0;
      else if (sync != last) cnt <= CNT_W'(1);
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync;
        cnt    <= '0;
      end else cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/stopwatch_cmd_conditioner.sv
// stopwatch_cmd_conditioner: debounced command decode into start/stop/clear pulses and run state
// Define STOPWATCH_TOGGLE_EN to make code 01 toggle start/stop and ignore code 10.
module stopwatch_cmd_conditioner
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [1:0] cmd_raw,
  output logic       start_pulse,
  output logic       stop_pulse,
  output logic       clear_pulse,
  output logic       running,
  output logic [1:0] cmd_stable
);
  logic [1:0] stable_q;
  logic accept, do_start, do_stop, do_clear;
  cmd_debounce #(
    .W(2),
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk(clk),
    .rst_n(rst_n),
    .raw(cmd_raw),
    .stable(cmd_stable)
  );
  // an accept is the first cycle of a new non-idle debounced code; disabled accepts are dropped
  always_comb begin
    accept   = ena && (cmd_stable != stable_q) && (cmd_stable != CMD_IDLE);
`ifdef STOPWATCH_TOGGLE_EN
    do_start = accept && (cmd_stable == CMD_START) && !running;
    do_stop  = accept && (cmd_stable == CMD_START) && running;
`else
    do_start = accept && (cmd_stable == CMD_START) && !running;
    do_stop  = accept && (cmd_stable == CMD_STOP) && running;
`endif
    do_clear = accept && (cmd_stable == CMD_CLEAR);
  end
  // register pulses and run state; stable_q tracks the code even while disabled so nothing replays
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stable_q    <= CMD_IDLE;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      clear_pulse <= 1'b0;
      running     <= 1'b0;
    end else begin
      stable_q    <= cmd_stable;
      start_pulse <= do_start;
      stop_pulse  <= do_stop;
      clear_pulse <= do_clear;
      running     <= (running | do_start) & ~do_stop & ~do_clear;
    end
endmodule

// File: tb/tb_stopwatch_cmd_conditioner.sv
// tb_stopwatch_cmd_conditioner: directed plus randomized checks against a cycle-level reference model
module tb_stopwatch_cmd_conditioner;
  localparam int S = 2;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ena = 1'b1;
  logic [1:0] cmd_raw = 2'b00;
  logic start_pulse, stop_pulse, clear_pulse, running;
  logic [1:0] cmd_stable;
  int n_checks = 0;
  int n_errors = 0;
  int n_start = 0, n_stop = 0, n_clear = 0;
  int a_start, a_stop, a_clear;
  bit chk_en = 1'b0;
  logic [1:0] q[$];
  int run_len;
  logic [1:0] m_prev, m_stable, pend_code;
  bit pend, m_run, m_start, m_stop, m_clear;

  stopwatch_cmd_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .cmd_raw(cmd_raw),
    .start_pulse(start_pulse),
    .stop_pulse(stop_pulse),
    .clear_pulse(clear_pulse),
    .running(running),
    .cmd_stable(cmd_stable)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [7:0] got, logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q = {};
    repeat (S) q.push_back(2'b00);
    run_len = 0;
    m_prev = 2'b00;
    m_stable = 2'b00;
    pend_code = 2'b00;
    pend = 0;
    m_run = 0;
    m_start = 0;
    m_stop = 0;
    m_clear = 0;
  endtask

  // raw is seen S edges late; a code is accepted once the synced value has held D edges and differs
  task automatic model_step();
    logic [1:0] s;
    s = q.pop_front();
    q.push_back(cmd_raw);
    m_start = 0;
    m_stop = 0;
    m_clear = 0;
    if (pend && ena) begin
      if (pend_code == 2'b11) begin
        m_clear = 1;
        m_run = 0;
      end
`ifdef STOPWATCH_TOGGLE_EN
      else if (pend_code == 2'b01) begin
        m_start = !m_run;
        m_stop = m_run;
        m_run = !m_run;
      end
`else
      else if (pend_code == 2'b01 && !m_run) begin
        m_start = 1;
        m_run = 1;
      end else if (pend_code == 2'b10 && m_run) begin
        m_stop = 1;
        m_run = 0;
      end
`endif
    end
    run_len = (s == m_prev) ? run_len + 1 : 1;
    m_prev = s;
    pend = 0;
    if (s != m_stable && run_len >= D) begin
      m_stable = s;
      pend = (s != 2'b00);
      pend_code = s;
    end
  endtask

  always @(posedge clk)
    if (!rst_n) model_reset();
    else model_step();

  always @(negedge clk) begin
    n_start += int'(start_pulse);
    n_stop += int'(stop_pulse);
    n_clear += int'(clear_pulse);
    if (chk_en) begin
      check("outputs", {2'b00, start_pulse, stop_pulse, clear_pulse, running, cmd_stable},
            {2'b00, m_start, m_stop, m_clear, m_run, m_stable});
      check("onehot", {7'b0, $onehot0({start_pulse, stop_pulse, clear_pulse})}, 8'd1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic hold_code(logic [1:0] c, int n);
    cmd_raw = c;
    cyc(n);
  endtask

  task automatic snap();
    a_start = n_start;
    a_stop = n_stop;
    a_clear = n_clear;
  endtask

  function automatic logic [7:0] outs();
    return {3'b000, start_pulse, stop_pulse, clear_pulse, running, 1'b0} | {6'b0, cmd_stable};
  endfunction

  task automatic async_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    model_reset();
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
    #2;
    // reset holds everything low regardless of the raw input
    for (int i = 0; i < 6; i++) hold_code(2'($urandom_range(0, 3)), 1);
    check("rst_outs", outs(), 8'h00);
    cmd_raw = 2'b00;
    rst_n = 1'b1;
    cyc(10);
    check("idle_after_rst", outs(), 8'h00);
    // start latency and width
    snap();
    cmd_raw = 2'b01;
    lat = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (start_pulse && lat < 0) lat = i;
    end
    @(posedge clk);
    #2;
    check("start_latency", 8'(lat), 8'd7);
    check("start_width", 8'(n_start - a_start), 8'd1);
    check("running_after_start", {7'b0, running}, 8'd1);
    hold_code(2'b00, 8);
    // clear back to stopped, then bounce a start code
    hold_code(2'b11, 10);
    hold_code(2'b00, 10);
    check("running_after_clear", {7'b0, running}, 8'd0);
    snap();
    repeat (5) begin
      hold_code(2'b01, 2);
      hold_code(2'b00, 2);
    end
    hold_code(2'b00, 10);
    check("bounce_pulses", 8'((n_start - a_start) + (n_stop - a_stop) + (n_clear - a_clear)), 8'd0);
    // sequence 01 -> 10 -> 11 -> 01
    snap();
    hold_code(2'b01, 10);
    hold_code(2'b10, 10);
    hold_code(2'b11, 10);
    hold_code(2'b01, 10);
    check("seq_start", 8'(n_start - a_start), 8'd2);
`ifdef STOPWATCH_TOGGLE_EN
    check("seq_stop", 8'(n_stop - a_stop), 8'd0);
`else
    check("seq_stop", 8'(n_stop - a_stop), 8'd1);
`endif
    check("seq_clear", 8'(n_clear - a_clear), 8'd1);
    check("seq_running", {7'b0, running}, 8'd1);
    snap();
    hold_code(2'b10, 10);
    hold_code(2'b00, 10);
    hold_code(2'b10, 10);
`ifdef STOPWATCH_TOGGLE_EN
    check("stop_repeat", 8'(n_stop - a_stop), 8'd0);
`else
    check("stop_repeat", 8'(n_stop - a_stop), 8'd1);
`endif
    // clear while running, no idle gap
    hold_code(2'b11, 10);
    hold_code(2'b00, 10);
    snap();
    hold_code(2'b01, 10);
    hold_code(2'b11, 10);
    check("clr_run_start", 8'(n_start - a_start), 8'd1);
    check("clr_run_clear", 8'(n_clear - a_clear), 8'd1);
    check("clr_run_running", {7'b0, running}, 8'd0);
    hold_code(2'b00, 10);
    // disabled accept is dropped and not replayed
    snap();
    ena = 1'b0;
    hold_code(2'b01, 10);
    ena = 1'b1;
    hold_code(2'b01, 10);
    check("ena_pulses", 8'((n_start - a_start) + (n_stop - a_stop) + (n_clear - a_clear)), 8'd0);
    check("ena_running", {7'b0, running}, 8'd0);
    hold_code(2'b00, 10);
    // repeated 01 then 10
    snap();
    hold_code(2'b01, 10);
    hold_code(2'b00, 10);
    hold_code(2'b01, 10);
    hold_code(2'b00, 10);
    check("rep_start", 8'(n_start - a_start), 8'd1);
`ifdef STOPWATCH_TOGGLE_EN
    check("rep_stop", 8'(n_stop - a_stop), 8'd1);
`else
    check("rep_stop", 8'(n_stop - a_stop), 8'd0);
`endif
    hold_code(2'b10, 10);
    hold_code(2'b00, 10);
    check("rep_stop_after_10", 8'(n_stop - a_stop), 8'd1);
    check("rep_running", {7'b0, running}, 8'd0);
    // reset mid-debounce, code still held afterwards is accepted once
    snap();
    hold_code(2'b01, 4);
    async_reset();
    check("mid_rst_stable", {6'b0, cmd_stable}, 8'd0);
    cyc(12);
    check("mid_rst_start", 8'(n_start - a_start), 8'd1);
    check("mid_rst_running", {7'b0, running}, 8'd1);
    hold_code(2'b00, 10);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) async_reset();
      hold_code(2'($urandom_range(0, 3)), $urandom_range(1, 9));
    end
    ena = 1'b1;
    hold_code(2'b00, 10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
